lock_code_compare: RTL and testbench

//   Datapath/evaluator consuming the lock FSM outputs (savePW, saveAT, LOCKED)
//   and producing its match input M. Stores the password on savePW, captures
//   the attempt on saveAT, compares the two, and counts failed unlock attempts.

---
 rtl/lock_code_compare.sv | 128 ++++++++++++
 tb/tb_lock_code_compare.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lock_code_compare.sv
// lock_code_compare: password/attempt store, match evaluator and failed-attempt
// tracking for the combination-lock FSM.
// Optional feature macro: LOCK_FAIL_LOCKOUT_EN enables the evaluation FSM,
// FAIL_CNT saturation counter and the timed lockout. Without it, FAIL_CNT and
// LOCKOUT are tied low and M is just the registered code comparison.
module lock_code_compare #(
  parameter int CODE_W         = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50000000
) (
  input  logic              CLK50,
  input  logic              reset,
  input  logic [CODE_W-1:0] SW,
  input  logic              savePW,
  input  logic              saveAT,
  input  logic              LOCKED,
  output logic              M,
  output logic [1:0]        FAIL_CNT,
  output logic              LOCKOUT,
  output logic [CODE_W-1:0] PW_Q
);

  logic [CODE_W-1:0] pw_q, pw_d;
  logic [CODE_W-1:0] at_q, at_d;
  logic              m_q, m_d;
  logic              lockout;

  // Code registers: savePW has priority, so a simultaneous saveAT leaves at_q alone
  always_comb begin
    pw_d = pw_q;
    at_d = at_q;
    if (savePW)      pw_d = SW;
    else if (saveAT) at_d = SW;
  end

  // Match flag is registered; lockout masks it so the FSM can never open
  always_comb begin
    m_d = (at_q == pw_q) && !lockout;
  end

  // Code and match state
  always_ff @(posedge CLK50) begin
    if (reset) begin
      pw_q <= '0;
      at_q <= '0;
      m_q  <= 1'b0;
    end else begin
      pw_q <= pw_d;
      at_q <= at_d;
      m_q  <= m_d;
    end
  end

`ifdef LOCK_FAIL_LOCKOUT_EN
  localparam int            TW    = $clog2(LOCKOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TLOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EVAL, S_LOCKOUT} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    fail_q, fail_d;
  logic [1:0]    fail_inc;

  // Evaluation FSM: an attempt is judged the cycle after saveAT drops,
  // using LOCKED to learn whether the lock FSM accepted it
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    fail_d   = fail_q;
    fail_inc = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
    unique case (state_q)
      S_IDLE:    if (saveAT && LOCKED) state_d = S_CAPTURE;
      S_CAPTURE: if (!saveAT)          state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_IDLE;
        if (!LOCKED) begin
          fail_d = 2'd0;
        end else begin
          fail_d = fail_inc;
          if (int'(fail_inc) >= MAX_FAILS) begin
            state_d = S_LOCKOUT;
            timer_d = TLOAD;
          end
        end
      end
      S_LOCKOUT: begin
        // Timer stops at zero; that cycle is the last one of the lockout
        if (timer_q == '0) begin
          fail_d  = 2'd0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, timer and failure-count registers
  always_ff @(posedge CLK50) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      fail_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  assign lockout  = (state_q == S_LOCKOUT);
  assign FAIL_CNT = fail_q;
`else
  // Feature disabled: LOCKED and the lockout parameters have no consumer
  localparam int unused_params = MAX_FAILS + LOCKOUT_CYCLES;
  logic unused_locked;
  assign unused_locked = LOCKED;
  assign lockout       = 1'b0;
  assign FAIL_CNT      = 2'd0;
`endif

  assign LOCKOUT = lockout;
  assign M       = m_q;
  assign PW_Q    = pw_q;

endmodule

// File: tb/tb_lock_code_compare.sv
// Bench for lock_code_compare: directed scenarios followed by random traffic,
// every cycle checked against a behavioural model of the lock evaluator.
module tb_lock_code_compare;
  localparam int CW = 8;
  localparam int MF = 3;
  localparam int LC = 16;

  logic          CLK50 = 1'b0;
  logic          reset, savePW, saveAT, LOCKED;
  logic [CW-1:0] SW;
  logic          M, LOCKOUT;
  logic [1:0]    FAIL_CNT;
  logic [CW-1:0] PW_Q;

  lock_code_compare #(.CODE_W(CW), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)) dut (
    .CLK50(CLK50), .reset(reset), .SW(SW), .savePW(savePW), .saveAT(saveAT),
    .LOCKED(LOCKED), .M(M), .FAIL_CNT(FAIL_CNT), .LOCKOUT(LOCKOUT), .PW_Q(PW_Q)
  );

  always #5 CLK50 = ~CLK50;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stored codes, match flag, failures, cycles of lockout left,
  // and whether an attempt is in progress / awaiting judgement.
  int          r_pw, r_at, r_fail, r_left;
  bit          r_m, r_armed, r_judge;
`ifdef LOCK_FAIL_LOCKOUT_EN
  localparam bit FEATURE = 1'b1;
`else
  localparam bit FEATURE = 1'b0;
`endif

  task automatic model(input bit r, input bit p, input bit a, input bit l, input int s);
    bit nm;
    if (r) begin
      r_pw = 0; r_at = 0; r_m = 0; r_fail = 0; r_left = 0; r_armed = 0; r_judge = 0;
      return;
    end
    nm = (r_at == r_pw) && (r_left == 0);
    if (p)      r_pw = s;
    else if (a) r_at = s;
    if (FEATURE) begin
      if (r_left > 0) begin
        r_left--;
        if (r_left == 0) r_fail = 0;
      end else if (r_judge) begin
        r_judge = 0;
        if (!l) r_fail = 0;
        else begin
          r_fail = (r_fail + 1 > 3) ? 3 : r_fail + 1;
          if (r_fail >= MF) r_left = LC;
        end
      end else if (r_armed) begin
        if (!a) begin r_armed = 0; r_judge = 1; end
      end else if (a && l) begin
        r_armed = 1;
      end
    end
    r_m = nm;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare at the falling edge
  task automatic step(input bit r, input bit p, input bit a, input bit l, input logic [7:0] s);
    reset = r; savePW = p; saveAT = a; LOCKED = l; SW = s;
    @(posedge CLK50);
    model(r, p, a, l, int'(s));
    @(negedge CLK50);
    chk("M",        {31'd0, M},        {31'd0, r_m});
    chk("FAIL_CNT", {30'd0, FAIL_CNT}, 32'(r_fail));
    chk("LOCKOUT",  {31'd0, LOCKOUT},  {31'd0, (r_left > 0)});
    chk("PW_Q",     {24'd0, PW_Q},     32'(r_pw));
  endtask

  // Attempt: saveAT for two cycles, then two idle cycles with LOCKED = lk
  task automatic attempt(input logic [7:0] code, input bit lk);
    step(0, 0, 1, 1, code);
    step(0, 0, 1, 1, code);
    step(0, 0, 0, lk, code);
    step(0, 0, 0, lk, code);
  endtask

  initial begin
    r_pw = 0; r_at = 0; r_m = 0; r_fail = 0; r_left = 0; r_armed = 0; r_judge = 0;
    reset = 1; savePW = 0; saveAT = 0; LOCKED = 1; SW = '0;
    @(negedge CLK50);
    // reset state
    step(1, 0, 0, 1, 8'h00);
    step(1, 0, 0, 1, 8'h00);
    // store password, then a correct attempt that the lock accepts
    repeat (3) step(0, 1, 0, 1, 8'hA5);
    attempt(8'hA5, 1'b0);
    // one rejected attempt
    attempt(8'h3C, 1'b1);
    // two more rejected -> lockout; correct code during lockout is ignored
    attempt(8'h3C, 1'b1);
    attempt(8'h3C, 1'b1);
    attempt(8'hA5, 1'b1);
    repeat (18) step(0, 0, 0, 1, 8'hA5);
    // lockout cut short by reset
    repeat (3) attempt(8'h77, 1'b1);
    repeat (5) step(0, 0, 0, 1, 8'h77);
    step(1, 0, 0, 1, 8'h77);
    repeat (2) step(0, 0, 0, 1, 8'h77);
    // savePW and saveAT together: password wins
    repeat (3) step(0, 1, 0, 1, 8'hA5);
    attempt(8'hA5, 1'b0);
    step(0, 1, 1, 1, 8'h11);
    step(0, 1, 1, 1, 8'h11);
    repeat (3) step(0, 0, 0, 1, 8'h11);
    // attempt re-asserted straight out of the judging cycle
    step(0, 0, 1, 1, 8'h22);
    step(0, 0, 0, 1, 8'h22);
    step(0, 0, 1, 1, 8'h11);
    step(0, 0, 0, 1, 8'h11);
    step(0, 0, 0, 0, 8'h11);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, p, a, l;
      logic [7:0] s;
      int pick;
      r = ($urandom_range(0, 399) == 0);
      p = ($urandom_range(0, 29) == 0);
      a = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 4) != 0);
      pick = $urandom_range(0, 2);
      s = (pick == 0) ? 8'hA5 : (pick == 1) ? 8'h3C : 8'($urandom);
      step(r, p, a, l, s);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
